// File: rtl/jk_bank_driver.sv
// ============================================================================
// Module   : jk_bank_driver
// Purpose  : Write-side controller for a negedge-clocked JK flip-flop bank.
//            Drives J/K toward a target word, verifies, and re-drives on miss.
//            Optional macro JK_TOGGLE_EXCITE_EN selects toggle-form excitation.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module jk_bank_driver #(
  parameter int WIDTH     = 4,
  parameter int RETRY_MAX = 3,
  localparam int RW       = (RETRY_MAX > 0) ? $clog2(RETRY_MAX + 1) : 1
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             REQ_VALID,
  output logic             REQ_READY,
  input  logic [WIDTH-1:0] REQ_DATA,
  input  logic [WIDTH-1:0] Q_FB,
  output logic [WIDTH-1:0] J,
  output logic [WIDTH-1:0] K,
  output logic             BUSY,
  output logic             DONE,
  output logic             ERR,
  output logic [RW-1:0]    RETRIES
);

  localparam logic [RW-1:0] C_RMAX = RW'(RETRY_MAX);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_DRIVE = 2'd1,
    S_CHECK = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [WIDTH-1:0] j_q, j_d, k_q, k_d;
  logic [RW-1:0]    retries_q, retries_d;
  logic             done_q, done_d, err_q, err_d;

  // Returns {J, K} moving present state q toward target t.
  function automatic logic [2*WIDTH-1:0] excite(input logic [WIDTH-1:0] q,
                                                input logic [WIDTH-1:0] t);
`ifdef JK_TOGGLE_EXCITE_EN
    return {q ^ t, q ^ t};
`else
    return {~q & t, q & ~t};
`endif
  endfunction

  always_comb begin
    state_d   = state_q;
    target_d  = target_q;
    j_d       = '0;
    k_d       = '0;
    retries_d = retries_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (REQ_VALID) begin
          target_d   = REQ_DATA;
          {j_d, k_d} = excite(Q_FB, REQ_DATA);
          retries_d  = '0;
          state_d    = S_DRIVE;
        end
      end
      S_DRIVE: begin
        state_d = S_CHECK;
      end
      S_CHECK: begin
        if (Q_FB == target_q) begin
          done_d  = 1'b1;
          state_d = S_IDLE;
        end else if (retries_q < C_RMAX) begin
          retries_d  = retries_q + 1'b1;
          {j_d, k_d} = excite(Q_FB, target_q);
          state_d    = S_DRIVE;
        end else begin
          err_d   = 1'b1;
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= S_IDLE;
      target_q  <= '0;
      j_q       <= '0;
      k_q       <= '0;
      retries_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      target_q  <= target_d;
      j_q       <= j_d;
      k_q       <= k_d;
      retries_q <= retries_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  assign REQ_READY = (state_q == S_IDLE) && !RST;
  assign BUSY      = (state_q == S_DRIVE) || (state_q == S_CHECK);
  assign J         = j_q;
  assign K         = k_q;
  assign DONE      = done_q;
  assign ERR       = err_q;
  assign RETRIES   = retries_q;

endmodule

`default_nettype wire

// File: tb/tb_jk_bank_driver.sv
// ============================================================================
// Module   : tb_jk_bank_driver
// Purpose  : Self-checking bench for jk_bank_driver with a negedge JK bank model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_jk_bank_driver;

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid;
  logic       req_ready;
  logic [3:0] req_data;
  logic [3:0] q_fb;
  logic [3:0] j, k;
  logic       busy, done, err;
  logic [1:0] retries;

  logic [3:0] bank_q = 4'b0000;
  logic [3:0] stuck0 = 4'b0000;
  logic       load_en = 1'b0;
  logic [3:0] load_val = 4'b0000;

  int passed = 0;
  int total  = 0;

  typedef struct {
    logic       is_err;
    logic [1:0] retries;
    logic [3:0] q;
    int         lat;
  } exp_t;
  exp_t sb[$];

  typedef struct {
    logic [3:0] q0;
    logic [3:0] req;
  } vec_t;
  vec_t vecs[6];

  jk_bank_driver #(.WIDTH(4), .RETRY_MAX(3)) dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_READY(req_ready),
    .REQ_DATA(req_data), .Q_FB(q_fb), .J(j), .K(k), .BUSY(busy),
    .DONE(done), .ERR(err), .RETRIES(retries)
  );

  always #5 clk = ~clk;

  // Bank model: JK flops on negedge; stuck-at-0 bits never rise.
  always @(negedge clk) begin
    logic [3:0] nq;
    if (load_en) begin
      nq = load_val;
    end else begin
      for (int i = 0; i < 4; i++) begin
        case ({j[i], k[i]})
          2'b10:   nq[i] = 1'b1;
          2'b01:   nq[i] = 1'b0;
          2'b11:   nq[i] = ~bank_q[i];
          default: nq[i] = bank_q[i];
        endcase
      end
    end
    bank_q <= nq & ~stuck0;
  end
  assign q_fb = bank_q;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic void model_exc(input logic [3:0] q, input logic [3:0] t,
                                    output logic [3:0] ej, output logic [3:0] ek);
    ej = '0;
    ek = '0;
    for (int i = 0; i < 4; i++) begin
      if (q[i] != t[i]) begin
`ifdef JK_TOGGLE_EXCITE_EN
        ej[i] = 1'b1;
        ek[i] = 1'b1;
`else
        if (t[i]) ej[i] = 1'b1;
        else      ek[i] = 1'b1;
`endif
      end
    end
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input logic [3:0] v);
    load_en  = 1'b1;
    load_val = v;
    @(negedge clk);
    #1;
    load_en  = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Issue one request, push the expectation, and wait for DONE/ERR to pop it.
  task automatic do_req(input string tag, input logic [3:0] data, input exp_t e,
                        input logic [3:0] drive_j);
    logic [3:0] ej, ek;
    int jcount;
    int cyc;
    bit seen;
    model_exc(q_fb, data, ej, ek);
    req_valid = 1'b1;
    req_data  = data;
    tick();
    req_valid = 1'b0;
    req_data  = ~data;
    chk({tag, " J"}, 32'(j), 32'(ej));
    chk({tag, " K"}, 32'(k), 32'(ek));
    chk({tag, " busy"}, 32'(busy), 32'd1);
    sb.push_back(e);
    jcount = (j == drive_j) ? 1 : 0;
    seen = 1'b0;
    cyc = 0;
    while (!seen && cyc < 30) begin
      tick();
      cyc++;
      if (cyc == 1) chk({tag, " JK idle in CHECK"}, 32'({j, k}), 32'd0);
      if (done || err) seen = 1'b1;
      else if (j == drive_j && drive_j != 4'b0) jcount++;
    end
    if (!seen) begin
      chk({tag, " timeout"}, 32'd0, 32'd1);
    end else if (sb.size() > 0) begin
      exp_t x;
      x = sb.pop_front();
      chk({tag, " err flag"}, 32'(err), 32'(x.is_err));
      chk({tag, " done flag"}, 32'(done), 32'(!x.is_err));
      chk({tag, " retries"}, 32'(retries), 32'(x.retries));
      chk({tag, " latency"}, 32'(cyc), 32'(x.lat));
      chk({tag, " bank"}, 32'(q_fb), 32'(x.q));
      if (drive_j != 4'b0) chk({tag, " drive count"}, 32'(jcount), 32'(x.retries) + 32'd1);
      tick();
      chk({tag, " pulse cleared"}, 32'({done, err}), 32'd0);
      chk({tag, " ready"}, 32'(req_ready), 32'd1);
      chk({tag, " retries held"}, 32'(retries), 32'(x.retries));
    end
  endtask

  initial begin
    logic [3:0] ej, ek;
    exp_t e;

    vecs[0] = '{4'b0000, 4'b1010};
    vecs[1] = '{4'b1100, 4'b1010};
    vecs[2] = '{4'b0110, 4'b0110};
    vecs[3] = '{4'b1111, 4'b0000};
    vecs[4] = '{4'b0000, 4'b1111};
    vecs[5] = '{4'b1001, 4'b0110};

    rst = 1'b1;
    req_valid = 1'b1;
    req_data = 4'b1111;
    tick();
    tick();
    chk("reset J", 32'(j), 32'd0);
    chk("reset K", 32'(k), 32'd0);
    chk("reset flags", 32'({busy, done, err}), 32'd0);
    chk("reset retries", 32'(retries), 32'd0);
    chk("reset ready", 32'(req_ready), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    #1;
    chk("ready after reset", 32'(req_ready), 32'd1);

    for (int i = 0; i < 6; i++) begin
      preload(vecs[i].q0);
      e = '{1'b0, 2'd0, vecs[i].req, 2};
      do_req($sformatf("vec%0d", i), vecs[i].req, e, 4'b0000);
    end

    // Bit 0 stuck at 0: every attempt misses, retries run out.
    stuck0 = 4'b0001;
    preload(4'b0000);
    e = '{1'b1, 2'd3, 4'b0000, 8};
    do_req("stuck", 4'b0001, e, 4'b0001);
    stuck0 = 4'b0000;

    // Second request held while busy; accepted at the end of the DONE cycle.
    preload(4'b0000);
    req_valid = 1'b1;
    req_data  = 4'b0011;
    tick();
    req_data  = 4'b0101;
    chk("b2b ready while busy", 32'(req_ready), 32'd0);
    tick();
    chk("b2b busy", 32'(busy), 32'd1);
    tick();
    chk("b2b first done", 32'(done), 32'd1);
    chk("b2b ready in done cycle", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    model_exc(4'b0011, 4'b0101, ej, ek);
    chk("b2b second J", 32'(j), 32'(ej));
    chk("b2b second K", 32'(k), 32'(ek));
    chk("b2b second busy", 32'({busy, done}), 32'b10);
    tick();
    tick();
    chk("b2b second done", 32'(done), 32'd1);
    chk("b2b bank", 32'(q_fb), 32'b0101);
    tick();

    // Asynchronous reset in the middle of DRIVE.
    preload(4'b0000);
    req_valid = 1'b1;
    req_data  = 4'b1111;
    tick();
    chk("abort J before reset", 32'(j), 32'hF);
    #1;
    rst = 1'b1;
    #1;
    chk("abort JK async", 32'({j, k}), 32'd0);
    chk("abort busy", 32'(busy), 32'd0);
    chk("abort ready", 32'(req_ready), 32'd0);
    tick();
    tick();
    chk("abort no pulse", 32'({done, err}), 32'd0);
    chk("abort bank held", 32'(q_fb), 32'd0);
    req_valid = 1'b0;
    rst = 1'b0;
    tick();
    e = '{1'b0, 2'd0, 4'b0110, 2};
    do_req("after abort", 4'b0110, e, 4'b0000);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

`default_nettype wire
